// File: rtl/jk_counter_bank_pkg.sv
// Shared mode encoding for the JK counter bank and its bench.
package jk_pkg;

    localparam int JK_MODE_W = 2;

    typedef enum logic [JK_MODE_W-1:0] {
        JK_MODE_JK   = 2'b00,
        JK_MODE_UP   = 2'b01,
        JK_MODE_DOWN = 2'b10,
        JK_MODE_HOLD = 2'b11
    } jk_mode_t;

endpackage

// File: rtl/jk_counter_bank_if.sv
// Control/status bundle of the JK counter bank; CLK and Clear stay plain ports.
interface jk_counter_bank_if
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             Preset;
    logic             EN;
    jk_mode_t         Mode;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_prim;
    logic             TC;

    modport master (
        output Preset, EN, Mode, J, K,
        input  Q, Q_prim, TC
    );

    modport slave (
        input  Preset, EN, Mode, J, K,
        output Q, Q_prim, TC
    );
endinterface

// File: rtl/jk_counter_bank_cell.sv
// One JK flip-flop with synchronous active-low Clear/Preset and a clock enable.
module jk_cell #(
    parameter logic PRESET_VAL = 1'b1
) (
    input  logic CLK,
    input  logic Clear,
    input  logic Preset,
    input  logic EN,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Q_prim
);

    logic r_q;

    always_ff @(posedge CLK) begin
        if (!Clear) begin
            r_q <= 1'b0;
        end else if (!Preset) begin
            r_q <= PRESET_VAL;
        end else if (EN) begin
            case ({J, K})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign Q      = r_q;
    assign Q_prim = ~r_q;

endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit JK register / modulo up-down counter built from jk_cell instances.
// Optional macro JK_COUNTER_SATURATE_EN makes UP/DOWN saturate instead of wrap.
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2**WIDTH
) (
    input  logic               CLK,
    input  logic               Clear,
    jk_counter_bank_if.slave   bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    if (MODULUS < 2 || MODULUS > (2**WIDTH)) begin : g_bad_modulus
        $error("jk_counter_bank: MODULUS out of range 2..2**WIDTH");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_prim;
    logic [WIDTH-1:0] w_tog_up;
    logic [WIDTH-1:0] w_tog_dn;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH:0]   w_q_ext;

    assign w_q_ext = {1'b0, w_q};

    // Ripple toggle-enables: a bit flips when all lower bits are 1 (up) or 0 (down).
    assign w_tog_up[0] = 1'b1;
    assign w_tog_dn[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_tog
        assign w_tog_up[gi] = w_tog_up[gi-1] &  w_q[gi-1];
        assign w_tog_dn[gi] = w_tog_dn[gi-1] & ~w_q[gi-1];
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        case (bus.Mode)
            JK_MODE_JK: begin
                w_j = bus.J;
                w_k = bus.K;
            end
            JK_MODE_UP: begin
                if (w_q >= MAX_VAL) begin
`ifdef JK_COUNTER_SATURATE_EN
                    w_j = MAX_VAL;
                    w_k = ~MAX_VAL;
`else
                    w_j = '0;
                    w_k = '1;
`endif
                end else begin
                    w_j = w_tog_up;
                    w_k = w_tog_up;
                end
            end
            JK_MODE_DOWN: begin
                if (w_q_ext >= MOD_EXT) begin
                    w_j = MAX_VAL;
                    w_k = ~MAX_VAL;
                end else if (w_q == '0) begin
`ifdef JK_COUNTER_SATURATE_EN
                    w_j = '0;
                    w_k = '0;
`else
                    w_j = MAX_VAL;
                    w_k = ~MAX_VAL;
`endif
                end else begin
                    w_j = w_tog_dn;
                    w_k = w_tog_dn;
                end
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_cell #(
            .PRESET_VAL (MAX_VAL[gi])
        ) u_cell (
            .CLK    (CLK),
            .Clear  (Clear),
            .Preset (bus.Preset),
            .EN     (bus.EN),
            .J      (w_j[gi]),
            .K      (w_k[gi]),
            .Q      (w_q[gi]),
            .Q_prim (w_q_prim[gi])
        );
    end

    assign bus.Q      = w_q;
    assign bus.Q_prim = w_q_prim;
    assign bus.TC     = bus.EN & (((bus.Mode == JK_MODE_UP)   & (w_q == MAX_VAL)) |
                                  ((bus.Mode == JK_MODE_DOWN) & (w_q == '0)));

endmodule

// File: doc/jk_counter_bank.md
Name: jk_counter_bank

Overview:
- Parametrised WIDTH-bit register built from JK cells, with four modes: per-bit JK register, modulo up-counter, modulo down-counter and hold.
- Successor to the single-bit JK flip-flop.
- Generalises that flip-flop in width, adds modulo counting and a terminal-count flag.
- Used as the building block for the counter and divider exercises in the digital circuits set.

Parameters:
- WIDTH, 4, number of JK cells / bits of Q.
- MODULUS, 2**WIDTH, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; the module must reject other values at elaboration.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Clear  input  1  synchronous active-low reset; Q <= 0.
- Preset  input  1  synchronous active-low preset; Q <= MODULUS-1.
- EN  input  1  enable; when 0 the bank holds, whatever the mode.
- Mode  input  2  operating mode: 00 JK, 01 UP, 10 DOWN, 11 HOLD.
- J  input  WIDTH  per-bit J inputs; used in JK mode only.
- K  input  WIDTH  per-bit K inputs; used in JK mode only.
- Q  output  WIDTH  registered state.
- Q_prim  output  WIDTH  bitwise complement of Q, always equal to ~Q.
- TC  output  1  terminal count; combinational from Q, Mode and EN.

Behaviour:
- Reset: Clear=0 at a rising edge gives Q=0 and Q_prim all ones. TC is then 1 only if EN=1 and Mode=DOWN.
- Priority per edge, highest first: Clear=0, then Preset=0, then EN=0 (hold), then Mode.
  - Clear and Preset both low: Clear wins.
- Latency: 1 cycle. Q reflects inputs sampled at an edge immediately after that edge.
- JK mode, per bit i:
  - J=0 K=0: hold.
  - J=0 K=1: Q[i] <= 0.
  - J=1 K=0: Q[i] <= 1.
  - J=1 K=1: toggle.
  - Values >= MODULUS are permitted in JK mode.
- UP mode:
  - Q < MODULUS-1: Q <= Q+1.
  - Q >= MODULUS-1: Q <= 0 (wrap; out-of-range values also return to 0).
- DOWN mode:
  - 0 < Q < MODULUS: Q <= Q-1.
  - Q == 0: Q <= MODULUS-1 (wrap).
  - Q >= MODULUS: Q <= MODULUS-1.
- HOLD mode: Q unchanged.
- Counting is realised as per-bit J/K = toggle-enable vectors driven into the JK cells, not as a behavioural adder on Q.
  - Wrap and out-of-range loads use J/K set/clear patterns.
- TC = EN & ((Mode==UP & Q==MODULUS-1) | (Mode==DOWN & Q==0)).
  - TC is 0 in JK and HOLD modes, and is not affected by Clear or Preset on the same cycle.
- Mode changes take effect at the next edge. There is no internal state beyond Q.
- Clear low mid-count: Q=0 on that edge, and counting resumes from 0 on the first edge where Clear=1.

Optional Feature:
- Macro JK_COUNTER_SATURATE_EN.
- Defined:
  - UP at Q >= MODULUS-1 loads/holds MODULUS-1.
  - DOWN at Q == 0 holds 0.
  - TC stays 1 while saturated.
- Undefined: wrap behaviour as above.
- JK mode is unaffected in both cases.

Decomposition:
- Package jk_pkg:
  - mode enum jk_mode_t, 2 bits: JK_MODE_JK, JK_MODE_UP, JK_MODE_DOWN, JK_MODE_HOLD.
  - constant JK_MODE_W = 2.
- Sub-module jk_cell:
  - one bit: CLK, sync active-low Clear/Preset, an enable, J, K, Q, Q_prim.
  - instantiated WIDTH times in a generate loop.
- Top-level holds only the toggle-enable/next-J/K logic and TC.

Test Plan (WIDTH=4, MODULUS=10 unless stated):
1. Clear=0 for 2 edges, then Clear=1, Mode=UP, EN=1 for 12 edges -> Q steps 0..9, 0, 1. TC=1 exactly while Q=9. Q_prim=~Q throughout.
2. Preset=0 for one edge, then Mode=DOWN for 11 edges -> Q=9, then 8..0, 9. TC=1 only while Q=0. Clear=0 and Preset=0 together -> Q=0.
3. Mode=JK from Q=0: J=1111 K=0000 -> Q=15; J=1010 K=0101 -> Q=1010; J=K=1111 -> Q=0101; J=K=0 -> hold 0101.
4. Q=15 via JK, then UP -> Q=0. Q=12 via JK, then DOWN -> Q=9. With EN=0 or Mode=HOLD, Q is held and TC=0.
5. Counting UP at Q=6, Clear=0 for one edge -> Q=0 next edge, then 1, 2 after release. Preset=0 during DOWN -> Q=9.
6. With JK_COUNTER_SATURATE_EN defined: UP from 7 for 5 edges -> 8, 9, 9, 9, 9 with TC held 1. DOWN from 1 -> 0, 0.
